// File: rtl/ps2_key_matrix.sv
// ps2_key_matrix: turns the PS/2 scancode stream from ps2in into the 16-bit CHIP-8 key matrix.
//   clk         system clock
//   rst         asynchronous, active-high reset
//   kbd_ready   byte-ready strobe from ps2in (asynchronous to clk)
//   kbd_data    scancode byte, stable while kbd_ready is high
//   key_matrix  bit n = 1 while CHIP-8 key n is held
//   any_key     OR of key_matrix, registered alongside it
//   key_event   one-cycle pulse when a key_matrix bit changes
//   key_code    key index of the last event (held)
//   key_down    1 = press, 0 = release for the last event (held)
module ps2_key_matrix #(
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        kbd_ready,
    input  logic [7:0]  kbd_data,
    output logic [15:0] key_matrix,
    output logic        any_key,
    output logic        key_event,
    output logic [3:0]  key_code,
    output logic        key_down
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BREAK     = 2'd1,
        EXT       = 2'd2,
        EXT_BREAK = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               s1, s2, s3;
    logic               byte_strobe;

    logic [15:0]        matrix_nxt;
    logic               event_nxt;
    logic [3:0]         code_nxt;
    logic               down_nxt;
    logic [4:0]         map;     // {valid, index}
    logic               mapped;
    logic [3:0]         idx;

    // Scancode set 2 to CHIP-8 hex keypad; bit 4 flags a mapped code.
    function automatic logic [4:0] map_code(input logic [7:0] c);
        case (c)
            8'h16: map_code = 5'h11;
            8'h1E: map_code = 5'h12;
            8'h26: map_code = 5'h13;
            8'h25: map_code = 5'h1C;
            8'h15: map_code = 5'h14;
            8'h1D: map_code = 5'h15;
            8'h24: map_code = 5'h16;
            8'h2D: map_code = 5'h1D;
            8'h1C: map_code = 5'h17;
            8'h1B: map_code = 5'h18;
            8'h23: map_code = 5'h19;
            8'h2B: map_code = 5'h1E;
            8'h1A: map_code = 5'h1A;
            8'h22: map_code = 5'h10;
            8'h21: map_code = 5'h1B;
            8'h2A: map_code = 5'h1F;
            default: map_code = 5'h00;
        endcase
    endfunction

    // Rising edge of the synchronised ready; kbd_data is stable by contract so it is used directly.
    assign byte_strobe = s2 & ~s3;
    assign map         = map_code(kbd_data);
    assign mapped      = map[4];
    assign idx         = map[3:0];

    // Matrix update for the byte arriving this cycle; events only on an actual bit change.
    always_comb begin
        matrix_nxt = key_matrix;
        event_nxt  = 1'b0;
        code_nxt   = key_code;
        down_nxt   = key_down;
        if (byte_strobe) begin
            case (state)
                IDLE: begin
                    if (kbd_data == 8'h00 || kbd_data == 8'hFF) begin
                        matrix_nxt = 16'h0000;
                    end else if (mapped && !key_matrix[idx]) begin
                        matrix_nxt[idx] = 1'b1;
                        event_nxt       = 1'b1;
                        code_nxt        = idx;
                        down_nxt        = 1'b1;
                    end
                end
                BREAK: begin
                    if (mapped && key_matrix[idx]) begin
                        matrix_nxt[idx] = 1'b0;
                        event_nxt       = 1'b1;
                        code_nxt        = idx;
                        down_nxt        = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Synchroniser, prefix FSM with timeout, and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            state      <= IDLE;
            tmo_cnt    <= '0;
            key_matrix <= 16'h0000;
            any_key    <= 1'b0;
            key_event  <= 1'b0;
            key_code   <= 4'h0;
            key_down   <= 1'b0;
        end else begin
            s1         <= kbd_ready;
            s2         <= s1;
            s3         <= s2;
            key_matrix <= matrix_nxt;
            any_key    <= |matrix_nxt;
            key_event  <= event_nxt;
            key_code   <= code_nxt;
            key_down   <= down_nxt;

            if (byte_strobe) begin
                // A byte wins over a coinciding timeout.
                tmo_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (kbd_data == 8'hF0)      state <= BREAK;
                        else if (kbd_data == 8'hE0) state <= EXT;
                        else                        state <= IDLE;
                    end
                    EXT:     state <= (kbd_data == 8'hF0) ? EXT_BREAK : IDLE;
                    default: state <= IDLE;
                endcase
            end else if (state == IDLE) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                state <= IDLE;
            end else begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_matrix.sv
// tb_ps2_key_matrix: scoreboard bench for ps2_key_matrix; expected key events are queued
// as bytes are sent and popped when the DUT pulses key_event.
module tb_ps2_key_matrix;

    localparam int unsigned TMO = 100;

    logic        clk;
    logic        rst;
    logic        kbd_ready;
    logic [7:0]  kbd_data;
    logic [15:0] key_matrix;
    logic        any_key;
    logic        key_event;
    logic [3:0]  key_code;
    logic        key_down;

    int checks;
    int errors;
    logic [4:0] evq[$];   // {code, down}

    ps2_key_matrix #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .kbd_ready  (kbd_ready),
        .kbd_data   (kbd_data),
        .key_matrix (key_matrix),
        .any_key    (any_key),
        .key_event  (key_event),
        .key_code   (key_code),
        .key_down   (key_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_event(input logic [3:0] code, input logic down);
        evq.push_back({code, down});
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        kbd_data  = b;
        kbd_ready = 1'b1;
        repeat (6) @(negedge clk);
        kbd_ready = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic check_matrix(input string tag, input logic [15:0] exp);
        check({tag, "_matrix"}, 32'(key_matrix), 32'(exp));
        check({tag, "_any"}, 32'(any_key), 32'(exp != 16'h0000));
    endtask

    // Scoreboard consumer: every key_event must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst && key_event) begin
            if (evq.size() == 0) begin
                check("unexpected_event", {27'd0, key_code, key_down}, 32'h0);
            end else begin
                logic [4:0] e;
                e = evq.pop_front();
                check("ev_code", 32'(key_code), 32'(e[4:1]));
                check("ev_down", 32'(key_down), 32'(e[0]));
            end
        end
    end

    initial begin
        int n;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        kbd_ready = 1'b0;
        kbd_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_matrix", 32'(key_matrix), 32'h0);
        check("rst_any", 32'(any_key), 32'h0);
        check("rst_event", 32'(key_event), 32'h0);
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_down", 32'(key_down), 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Basic press / release of key 1
        expect_event(4'h1, 1'b1);
        send_byte(8'h16);
        check_matrix("press1", 16'h0002);
        send_byte(8'hF0);
        check_matrix("f0_pending", 16'h0002);
        expect_event(4'h1, 1'b0);
        send_byte(8'h16);
        check_matrix("release1", 16'h0000);

        // Typematic repeats produce one press event
        expect_event(4'h7, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h1C);
            check_matrix("typematic7", 16'h0080);
        end
        send_byte(8'hF0);
        expect_event(4'h7, 1'b0);
        send_byte(8'h1C);
        check_matrix("release7", 16'h0000);

        // Multiple holds, plus latency from ready rise to event pulse
        expect_event(4'h0, 1'b1);
        send_byte(8'h22);
        check_matrix("press0", 16'h0001);
        expect_event(4'hF, 1'b1);
        @(posedge clk);
        #1;
        kbd_data  = 8'h2A;
        kbd_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (key_event) break;
        end
        check("latency", 32'(n), 32'd3);
        repeat (6) @(negedge clk);
        kbd_ready = 1'b0;
        repeat (10) @(negedge clk);
        check_matrix("pressF", 16'h8001);
        send_byte(8'hF0);
        expect_event(4'h0, 1'b0);
        send_byte(8'h22);
        check_matrix("release0", 16'h8000);
        send_byte(8'hF0);
        expect_event(4'hF, 1'b0);
        send_byte(8'h2A);
        check_matrix("releaseF", 16'h0000);

        // Extended codes and non-key bytes leave the matrix alone
        expect_event(4'h1, 1'b1);
        send_byte(8'h16);
        send_byte(8'hE0);
        send_byte(8'h16);
        check_matrix("ext_make", 16'h0002);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h16);
        check_matrix("ext_break", 16'h0002);
        send_byte(8'hAA);
        send_byte(8'hFA);
        send_byte(8'h5A);
        check_matrix("ignored", 16'h0002);
        send_byte(8'hF0);
        expect_event(4'h1, 1'b0);
        send_byte(8'h16);
        check_matrix("release1b", 16'h0000);

        // Break prefix times out; following code is a press
        send_byte(8'hF0);
        repeat (TMO + 10) @(negedge clk);
        expect_event(4'h1, 1'b1);
        send_byte(8'h16);
        check_matrix("timeout_press", 16'h0002);
        send_byte(8'hF0);
        expect_event(4'h1, 1'b0);
        send_byte(8'h16);

        // Overrun byte clears all held keys silently
        expect_event(4'h1, 1'b1);
        send_byte(8'h16);
        expect_event(4'h2, 1'b1);
        send_byte(8'h1E);
        expect_event(4'h3, 1'b1);
        send_byte(8'h26);
        check_matrix("hold123", 16'h000E);
        send_byte(8'hFF);
        check_matrix("overrun", 16'h0000);

        // Reset mid-sequence drops the pending break prefix
        expect_event(4'h1, 1'b1);
        send_byte(8'h16);
        send_byte(8'hF0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_matrix", 32'(key_matrix), 32'h0);
        check("midrst_any", 32'(any_key), 32'h0);
        check("midrst_code", 32'(key_code), 32'h0);
        check("midrst_down", 32'(key_down), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        expect_event(4'h1, 1'b1);
        send_byte(8'h16);
        check_matrix("post_rst_press", 16'h0002);

        repeat (5) @(negedge clk);
        check("evq_drained", 32'(evq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_matrix.md
Name: ps2_key_matrix

Overview:
- Decodes the PS/2 scancode byte stream from ps2in into the 16-bit CHIP-8 key matrix consumed by the cpu keyMatrix input.
- Runs on the system clock. Synchronises the ps2in ready strobe into the clk domain and tracks make, break (F0) and extended (E0) prefixes with a small FSM.
- Emits a one-cycle key event (index and direction) for wait-for-key instructions.

Parameters:
- TIMEOUT_CYCLES, 200000, clk cycles allowed between prefix and following byte before the FSM abandons the sequence (2 ms at 100 MHz); counter width = $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- kbd_ready  input  1  byte-ready strobe from ps2in, asynchronous to clk.
- kbd_data  input  8  scancode byte from ps2in; stable from kbd_ready rise until it falls (≥4 clk).
- key_matrix  output  16  bit n = 1 while CHIP-8 key n is held.
- any_key  output  1  OR of key_matrix, registered with it.
- key_event  output  1  one-cycle pulse on a key_matrix bit change.
- key_code  output  4  index of key for the last event; held until next event.
- key_down  output  1  1 = press, 0 = release for the last event; held.

Behaviour:
- Reset, asynchronous, active-high, only on rst:
  - key_matrix=0, any_key=0, key_event=0, key_code=0, key_down=0.
  - FSM=IDLE, timeout counter=0, synchroniser flops=0.
  - Reset mid-sequence discards any pending prefix.
- Input sync:
  - kbd_ready passes through 2 flops (s1, s2) plus a previous-value flop s3.
  - byte_strobe = s2 & ~s3. kbd_data is sampled in that cycle without its own synchroniser (stable by contract).
- Latency: kbd_ready first sampled high at clk edge k. Updates to key_matrix, any_key, key_code and key_down are registered at edge k+2; key_event is high for exactly the cycle after k+2.
- Mapping (scancode -> key):
  - 16->1, 1E->2, 26->3, 25->C
  - 15->4, 1D->5, 24->6, 2D->D
  - 1C->7, 1B->8, 23->9, 2B->E
  - 1A->A, 22->0, 21->B, 2A->F
  - All other codes are unmapped.
- FSM states: IDLE, BREAK, EXT, EXT_BREAK. Transitions on byte_strobe:
  - IDLE:
    - F0 -> BREAK; E0 -> EXT.
    - 00 or FF (overrun/error) -> key_matrix cleared to 0, no event, stay IDLE.
    - Mapped code -> press; stay IDLE.
    - Anything else (AA, FA, E1, unmapped) ignored.
  - BREAK:
    - Mapped code -> release, then IDLE. Any other byte -> IDLE, no effect.
    - F0 or E0 received here is treated as an unmapped data byte.
  - EXT: F0 -> EXT_BREAK; any other byte -> IDLE, ignored (no extended keys are mapped).
  - EXT_BREAK: any byte -> IDLE, ignored.
- Press/release rules:
  - A press sets bit n. key_event fires only if bit n was 0, so typematic repeats produce no event.
  - A release clears bit n. key_event fires only if bit n was 1, so a stray break produces no event.
  - key_code and key_down update only when key_event fires.
  - Simultaneous holds are independent: there is no rollover limit within 16 keys.
- Timeout:
  - The counter resets to 0 on every byte_strobe and counts only in BREAK, EXT or EXT_BREAK.
  - When it reaches TIMEOUT_CYCLES the FSM returns to IDLE with no matrix change. The counter saturates and is cleared in IDLE.
  - If byte_strobe and the timeout coincide, byte_strobe wins and is processed in the current state.
- any_key equals |key_matrix as registered, updated the same cycle.
- A kbd_ready pulse shorter than 2 clk may be missed; this is permitted because ps2in holds it for far longer.

Test Plan:
- Reset, then bytes 16, F0, 16 spaced 50 µs apart -> key_matrix 0002 then 0000. key_event pulses twice: (code 1, down 1) then (code 1, down 0). any_key goes 1 then 0.
- Bytes 1C, 1C, 1C (typematic), then F0 1C -> exactly 2 key_event pulses. Bit 7 is set after the first byte and cleared after F0 1C.
- Bytes 22, 2A, then F0 22 -> key_matrix 0001, 8001, 8000. key_code sequence 0, F, 0. Also verify 3-cycle latency from the kbd_ready rise to the key_event pulse.
- Bytes E0 16, then E0 F0 16 (extended codes) with key 1 previously held via 16 -> key_matrix stays 0002 and no events occur. Bytes AA, FA, 5A -> no change.
- Byte F0, then a gap of TIMEOUT_CYCLES+10 cycles, then 16 -> treated as a press: key_matrix bit 1 set, key_event with down=1.
- Keys 1, 2, 3 held; then byte FF -> key_matrix 0000 with no key_event. Separately, assert rst mid-sequence (after F0) -> all outputs 0, and the next byte 16 is a press.
